mips_mc_control: RTL and testbench

- Multicycle main-control FSM for the MIPS datapath.
- Decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback steps.
- Drives AluOp[1:0] for the ALU-control decoder using its encoding: 00 add (lw/sw/PC+4), 01 sub (beq), 10 funct-field (R-type), 11 addi.
- Adds a memory-ready handshake so fetch and data accesses can stall on slow memory.

---
 rtl/mips_mc_control.sv | 200 ++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main-control FSM with a memory-ready stall handshake and a wait-counter timeout.
// Define MIPS_ILLEGAL_TRAP_EN to send unlisted opcodes to a terminal TRAP state instead of FETCH.
module mips_mc_control #(
    parameter int FETCH_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic [1:0] PCSource,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
`ifdef MIPS_ILLEGAL_TRAP_EN
        ADDIWB = 4'd11,
        TRAP   = 4'd12
`else
        ADDIWB = 4'd11
`endif
    } state_t;

    localparam int CNT_W = (FETCH_WAIT_MAX > 1) ? $clog2(FETCH_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FETCH_WAIT_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting, timeout;

    // The branch decision is taken by the datapath from PCWriteCond & Zero.
    logic unused_zero;
    assign unused_zero = Zero;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;

    assign waiting = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !mem_ready;
    assign timeout = waiting && (FETCH_WAIT_MAX != 0) && (cnt_q + 1'b1 == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating stall counter, restarted whenever a new state is entered.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (Opcode)
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000000:            state_d = EXEC;
                    6'b000100:            state_d = BRANCH;
                    6'b000010:            state_d = JUMP;
                    6'b001000:            state_d = ADDIEX;
`ifdef MIPS_ILLEGAL_TRAP_EN
                    default:              state_d = TRAP;
`else
                    default:              state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (Opcode == 6'b101011) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = RWB;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
`ifdef MIPS_ILLEGAL_TRAP_EN
            TRAP: state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Outputs are held low for as long as reset is asserted, not just from the next edge.
    assign PCWrite     = rst_n & pc_write;
    assign PCWriteCond = rst_n & pc_write_cond;
    assign IorD        = rst_n & iord;
    assign MemRead     = rst_n & mem_read;
    assign MemWrite    = rst_n & mem_write;
    assign IRWrite     = rst_n & ir_write;
    assign MemtoReg    = rst_n & mem_to_reg;
    assign RegDst      = rst_n & reg_dst;
    assign RegWrite    = rst_n & reg_write;
    assign AluSrcA     = rst_n & alu_src_a;
    assign AluSrcB     = rst_n ? alu_src_b : 2'b00;
    assign AluOp       = rst_n ? alu_op : 2'b00;
    assign PCSource    = rst_n ? pc_source : 2'b00;
    assign mem_timeout = rst_n & timeout;
    assign state_o     = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: random instruction streams with random memory stalls against a
// phase-list model, plus directed fetch-timeout, reset-during-store-stall and illegal-opcode cases.
module tb_mips_mc_control;

    localparam int WMAX = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       Zero, mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, AluSrcA, mem_timeout;
    logic [1:0] AluSrcB, AluOp, PCSource;
    logic [3:0] state_o;

    mips_mc_control #(.FETCH_WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
        .PCSource(PCSource), .mem_timeout(mem_timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    logic [20:0] act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, AluSrcA, AluSrcB, AluOp, PCSource, mem_timeout, state_o};

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    logic [5:0] legal [6] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI};

    int         phases[$];
    logic [5:0] pend[$];
    logic [5:0] cur_op;
    int         waits;
    logic       last_to, last_irw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control word for a state as listed in the control table.
    function automatic logic [20:0] exp_outs(input int st, input logic mr, input logic to);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; aop = 2'b11; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, to, 4'(st)};
    endfunction

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input logic mr, input logic z);
        int   st;
        logic is_mem, to;
        if (phases.size() == 0) begin
            cur_op = (pend.size() != 0) ? pend.pop_front() : legal[$urandom_range(0, 5)];
            phases.push_back(0);
            phases.push_back(1);
            case (cur_op)
                OP_LW:   begin phases.push_back(2); phases.push_back(3); phases.push_back(4); end
                OP_SW:   begin phases.push_back(2); phases.push_back(5); end
                OP_R:    begin phases.push_back(6); phases.push_back(7); end
                OP_BEQ:  phases.push_back(8);
                OP_J:    phases.push_back(9);
                OP_ADDI: begin phases.push_back(10); phases.push_back(11); end
                default: begin
`ifdef MIPS_ILLEGAL_TRAP_EN
                    phases.push_back(12);
`endif
                end
            endcase
            waits = 0;
        end
        Opcode = cur_op; mem_ready = mr; Zero = z;
        st     = phases[0];
        is_mem = (st == 0 || st == 3 || st == 5);
        to     = is_mem && !mr && (WMAX != 0) && (waits + 1 == WMAX);
        @(negedge clk);
        check("ctrl", 32'(act), 32'(exp_outs(st, mr, to)));
        last_to  = mem_timeout;
        last_irw = IRWrite;
        if (is_mem && !mr) waits++;
        else if (st != 12) begin
            void'(phases.pop_front());
            waits = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic finish_instr();
        for (int i = 0; i < 64 && phases.size() != 0; i++) cycle(1'b1, 1'($urandom));
    endtask

    task automatic model_reset();
        phases.delete();
        pend.delete();
        waits = 0;
    endtask

    initial begin
        int to_cnt, to_at, irw_cnt;
        rst_n = 1'b0; mem_ready = 1'b0; Zero = 1'b0; Opcode = 6'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(act), 32'd0);
        rst_n = 1'b1;

        // Directed no-stall sequences: lw, R-type, beq taken/not, j, addi, sw.
        pend.push_back(OP_LW);
        pend.push_back(OP_R);
        pend.push_back(OP_BEQ);
        pend.push_back(OP_BEQ);
        pend.push_back(OP_J);
        pend.push_back(OP_ADDI);
        pend.push_back(OP_SW);
        repeat (5) cycle(1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0);
        check("seq_done", 32'(phases.size()), 32'd0);

        // Randomized stream with random stalls.
        for (int i = 0; i < 1500; i++) cycle(($urandom_range(0, 9) < 7), 1'($urandom));
        finish_instr();

        // Fetch held off for 20 cycles.
        to_cnt = 0; to_at = 0; irw_cnt = 0;
        pend.push_back(OP_R);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b0);
            if (last_to) begin to_cnt++; to_at = i; end
            if (last_irw) irw_cnt++;
        end
        check("to_pulses", 32'(to_cnt), 32'd1);
        check("to_cycle", 32'(to_at), 32'(WMAX));
        check("irw_stall", 32'(irw_cnt), 32'd0);
        cycle(1'b1, 1'b0);
        check("irw_rise", 32'(last_irw), 32'd1);
        finish_instr();

        // Reset during a store stall.
        pend.push_back(OP_SW);
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        mem_ready = 1'b0;
        #1 check("memwr_stall", 32'(MemWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1 check("rst_async", 32'(act), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check("rst_state", 32'(state_o), 32'd0);
        pend.push_back(OP_R);
        repeat (4) cycle(1'b1, 1'b0);
        finish_instr();

        // Unlisted opcode.
        pend.push_back(6'b111111);
        repeat (2) cycle(1'b1, 1'b0);
`ifdef MIPS_ILLEGAL_TRAP_EN
        repeat (6) cycle(1'b1, 1'b0);
        check("trap_state", 32'(state_o), 32'd12);
`else
        check("nop_state", 32'(state_o), 32'd0);
`endif
        rst_n = 1'b0;
        #1 check("rst_final", 32'(act), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        pend.push_back(OP_ADDI);
        repeat (4) cycle(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
